// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall sequencer.
//   HAZ_REG_W  : default register-index width
//   ST_*       : state encodings for RUN / MD_WAIT
//   haz_ctrl_t : bundle of pipeline control outputs
//   CTRL_NOP   : control values forced while in reset (everything frozen, nops injected)
//   CTRL_RUN   : control values when no hazard is present
package hazard_pkg;

  localparam int unsigned HAZ_REG_W = 5;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  typedef enum logic {
    StRun    = ST_RUN,
    StMdWait = ST_MD_WAIT
  } haz_state_e;

  typedef struct packed {
    logic pc_we;
    logic fd_we;
    logic dx_we;
    logic fd_flush;
    logic dx_bubble;
    logic xm_bubble;
  } haz_ctrl_t;

  localparam haz_ctrl_t CTRL_NOP = '{
    pc_we:     1'b0,
    fd_we:     1'b0,
    dx_we:     1'b0,
    fd_flush:  1'b1,
    dx_bubble: 1'b1,
    xm_bubble: 1'b1
  };

  localparam haz_ctrl_t CTRL_RUN = '{
    pc_we:     1'b1,
    fd_we:     1'b1,
    dx_we:     1'b1,
    fd_flush:  1'b0,
    dx_bubble: 1'b0,
    xm_bubble: 1'b0
  };

endpackage

// File: rtl/md_watchdog.sv
// Watchdog for multi-cycle mult/div waits.
// Counts cycles while enabled; flags timeout on the cycle the count reaches MD_TIMEOUT-1.
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  synchronous clear of the count (has priority over enable)
//   enable   in  advance the count this cycle
//   timeout  out enable is high and the count is at its terminal value
module md_watchdog #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [W-1:0] TC = W'(MD_TIMEOUT - 1);

  logic [W-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (enable) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign timeout = enable & (wd_cnt_q == TC);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall sequencer for a 5-stage pipeline.
// Generates PC / F/D / D/X write enables, the F/D flush, the decode bubble (dx_bubble)
// and the X/M bubble for load-use stalls, taken redirects and mult/div waits.
// Optional feature: define HAZ_PERF_CNT_EN to build a saturating stall-cycle counter;
// otherwise stall_cnt is tied to zero.
// Ports:
//   clock, reset_n               clock and asynchronous active-low reset
//   fd_rs1, fd_rs2, fd_uses_rs2  source operands of the instruction in decode
//   dx_memread, dx_rd            load indication and destination of the instruction in execute
//   redirect_x                   taken branch / jump resolved in execute
//   md_start, md_ready           mult/div launch and completion handshake
//   pc_we, fd_we, dx_we          latch write enables
//   fd_flush, dx_bubble, xm_bubble  nop injection controls
//   md_busy                      waiting on mult/div
//   md_err                       sticky mult/div timeout flag
//   stall_cnt                    stall-cycle performance counter
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = HAZ_REG_W,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs2,
  input  logic             dx_memread,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             redirect_x,
  input  logic             md_start,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             dx_we,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  haz_state_e state_q, state_d;
  logic       md_err_q, md_err_d;
  logic       wd_timeout;
  logic       md_stall;
  logic       load_use;
  haz_ctrl_t  ctrl;

  md_watchdog #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q == StRun),
    .enable  (state_q == StMdWait),
    .timeout (wd_timeout)
  );

  // The timeout cycle releases the pipeline even though md_ready never came.
  assign md_stall = ((state_q == StRun) & md_start & ~md_ready) |
                    ((state_q == StMdWait) & ~md_ready & ~wd_timeout);

  assign load_use = dx_memread & (dx_rd != '0) &
                    ((dx_rd == fd_rs1) | (fd_uses_rs2 & (dx_rd == fd_rs2)));

  always_comb begin
    ctrl = CTRL_RUN;
    if (md_stall) begin
      // A jump cannot be in X while it holds a mult/div, so redirect_x is ignored here.
      ctrl.pc_we     = 1'b0;
      ctrl.fd_we     = 1'b0;
      ctrl.dx_we     = 1'b0;
      ctrl.xm_bubble = 1'b1;
    end else if (redirect_x) begin
      // Squashes the decode instruction, so any load-use stall on it is moot.
      ctrl.fd_flush  = 1'b1;
      ctrl.dx_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_we     = 1'b0;
      ctrl.fd_we     = 1'b0;
      ctrl.dx_bubble = 1'b1;
    end
    if (!reset_n) begin
      ctrl = CTRL_NOP;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_err_d = md_err_q;
    unique case (state_q)
      StRun: begin
        if (md_start && !md_ready) begin
          state_d = StMdWait;
        end
      end
      StMdWait: begin
        if (md_ready) begin
          state_d = StRun;
        end else if (wd_timeout) begin
          state_d  = StRun;
          md_err_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_err_q <= md_err_d;
    end
  end

  assign pc_we     = ctrl.pc_we;
  assign fd_we     = ctrl.fd_we;
  assign dx_we     = ctrl.dx_we;
  assign fd_flush  = ctrl.fd_flush;
  assign dx_bubble = ctrl.dx_bubble;
  assign xm_bubble = ctrl.xm_bubble;
  assign md_busy   = reset_n & (state_q == StMdWait);
  assign md_err    = md_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (!ctrl.pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [REG_W-1:0] fd_rs1 = '0;
  logic [REG_W-1:0] fd_rs2 = '0;
  logic             fd_uses_rs2 = 1'b0;
  logic             dx_memread = 1'b0;
  logic [REG_W-1:0] dx_rd = '0;
  logic             redirect_x = 1'b0;
  logic             md_start = 1'b0;
  logic             md_ready = 1'b0;
  logic             pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_bubble, md_busy, md_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_unit #(
    .REG_W      (REG_W),
    .MD_TIMEOUT (64),
    .CNT_W      (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fd_rs1      (fd_rs1),
    .fd_rs2      (fd_rs2),
    .fd_uses_rs2 (fd_uses_rs2),
    .dx_memread  (dx_memread),
    .dx_rd       (dx_rd),
    .redirect_x  (redirect_x),
    .md_start    (md_start),
    .md_ready    (md_ready),
    .pc_we       (pc_we),
    .fd_we       (fd_we),
    .fd_flush    (fd_flush),
    .dx_we       (dx_we),
    .dx_bubble   (dx_bubble),
    .xm_bubble   (xm_bubble),
    .md_busy     (md_busy),
    .md_err      (md_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] exp);
    check({tag, ".pc_we"},     {31'd0, pc_we},     {31'd0, exp[5]});
    check({tag, ".fd_we"},     {31'd0, fd_we},     {31'd0, exp[4]});
    check({tag, ".dx_we"},     {31'd0, dx_we},     {31'd0, exp[3]});
    check({tag, ".fd_flush"},  {31'd0, fd_flush},  {31'd0, exp[2]});
    check({tag, ".dx_bubble"}, {31'd0, dx_bubble}, {31'd0, exp[1]});
    check({tag, ".xm_bubble"}, {31'd0, xm_bubble}, {31'd0, exp[0]});
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef HAZ_PERF_CNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int busy;
    // {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble}
    logic [5:0] c_run;
    logic [5:0] c_nop;
    logic [5:0] c_md;
    logic [5:0] c_lu;
    logic [5:0] c_redir;
    c_run   = 6'b111000;
    c_nop   = 6'b000111;
    c_md    = 6'b000001;
    c_lu    = 6'b001010;
    c_redir = 6'b111110;

    // Reset held low from time 0.
    #12;
    check_ctrl("rst_hold", c_nop);
    check("rst_hold.md_busy", {31'd0, md_busy}, 32'd0);
    check("rst_hold.md_err", {31'd0, md_err}, 32'd0);
    check("rst_hold.stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check_ctrl("rst_release", c_run);

    // Mult/div, md_ready arrives on the 18th cycle (after 17 stall cycles).
    tick();
    md_start = 1'b1;
    #1;
    check_ctrl("md_trigger", c_md);
    check("md_trigger.md_busy", {31'd0, md_busy}, 32'd0);
    stalls = 0;
    busy   = 0;
    for (int i = 0; i < 17; i++) begin
      stalls += (pc_we == 1'b0) ? 1 : 0;
      busy   += (md_busy == 1'b1) ? 1 : 0;
      tick();
      md_start = 1'b0;
      // A redirect during the wait must not leak through.
      redirect_x = (i == 4);
      #1;
      if (i == 4) check("md_redirect_ignored.fd_flush", {31'd0, fd_flush}, 32'd0);
    end
    redirect_x = 1'b0;
    md_ready   = 1'b1;
    #1;
    check("md17.stall_cycles", 32'(stalls), 32'd17);
    check("md17.busy_stalled", 32'(busy), 32'd16);
    check_ctrl("md17.ready", c_run);
    check("md17.ready.md_busy", {31'd0, md_busy}, 32'd1);
    tick();
    md_ready = 1'b0;
    #1;
    check("md17.after.md_busy", {31'd0, md_busy}, 32'd0);
    check("md17.after.md_err", {31'd0, md_err}, 32'd0);
    check("md17.stall_cnt", 32'(stall_cnt), exp_cnt(17));

    // Immediate ready: no stall, stays in RUN.
    md_start = 1'b1;
    md_ready = 1'b1;
    #1;
    check_ctrl("md_imm", c_run);
    tick();
    md_start = 1'b0;
    md_ready = 1'b0;
    #1;
    check("md_imm.md_busy", {31'd0, md_busy}, 32'd0);

    // Timeout: md_ready never comes; 64 cycles in MD_WAIT, last one releases.
    md_start = 1'b1;
    #1;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      stalls += (pc_we == 1'b0) ? 1 : 0;
      tick();
      md_start = 1'b0;
      #1;
    end
    check("md_to.stall_cycles", 32'(stalls), 32'd64);
    check_ctrl("md_to.release", c_run);
    check("md_to.release.md_busy", {31'd0, md_busy}, 32'd1);
    check("md_to.release.md_err", {31'd0, md_err}, 32'd0);
    tick();
    #1;
    check("md_to.after.md_busy", {31'd0, md_busy}, 32'd0);
    check("md_to.after.md_err", {31'd0, md_err}, 32'd1);
    check("md_to.stall_cnt", 32'(stall_cnt), exp_cnt(81));
    tick();
    tick();
    #1;
    check("md_to.sticky.md_err", {31'd0, md_err}, 32'd1);

    // Load-use via rs2.
    dx_memread  = 1'b1;
    dx_rd       = 5'd5;
    fd_rs1      = 5'd3;
    fd_rs2      = 5'd5;
    fd_uses_rs2 = 1'b1;
    #1;
    check_ctrl("lu_rs2", c_lu);
    tick();
    dx_memread = 1'b0;
    #1;
    check_ctrl("lu_rs2.next", c_run);
    check("lu_rs2.md_busy", {31'd0, md_busy}, 32'd0);
    // rs2 match but rs2 not read.
    dx_memread  = 1'b1;
    fd_uses_rs2 = 1'b0;
    #1;
    check_ctrl("lu_rs2_unused", c_run);
    // rs1 match.
    fd_rs1 = 5'd5;
    #1;
    check_ctrl("lu_rs1", c_lu);
    // Register 0 never stalls.
    dx_rd       = 5'd0;
    fd_rs1      = 5'd0;
    fd_rs2      = 5'd0;
    fd_uses_rs2 = 1'b1;
    #1;
    check_ctrl("lu_r0", c_run);
    // Not a load.
    dx_rd      = 5'd7;
    fd_rs1     = 5'd7;
    dx_memread = 1'b0;
    #1;
    check_ctrl("lu_noload", c_run);

    // Redirect overrides load-use.
    dx_memread = 1'b1;
    redirect_x = 1'b1;
    #1;
    check_ctrl("redir_lu", c_redir);
    dx_memread = 1'b0;
    #1;
    check_ctrl("redir_only", c_redir);
    tick();
    redirect_x = 1'b0;
    #1;
    check("pre_rst.stall_cnt", 32'(stall_cnt), exp_cnt(82));

    // Mid-run reset while waiting on mult/div.
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    #1;
    check("mid.md_busy", {31'd0, md_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_ctrl("mid_rst", c_nop);
    check("mid_rst.md_busy", {31'd0, md_busy}, 32'd0);
    check("mid_rst.md_err", {31'd0, md_err}, 32'd0);
    check("mid_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check_ctrl("mid_rst.release", c_run);
    check("mid_rst.release.md_err", {31'd0, md_err}, 32'd0);
    tick();
    #1;
    check("mid_rst.after.md_busy", {31'd0, md_busy}, 32'd0);
    check("mid_rst.after.pc_we", {31'd0, pc_we}, 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
